// File: rtl/warx_pkg.sv
// Shared types and helpers for the WARX round datapath.
// Lane i of a 128-bit state occupies bits [16i+15:16i].
package warx_pkg;

   localparam int unsigned LANES  = 8;
   localparam int unsigned LANE_W = 16;

   typedef logic [LANE_W-1:0] lane_t;
   typedef lane_t [LANES-1:0] state_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

   function automatic lane_t rotl16(input lane_t x, input logic [3:0] amt);
      logic [2*LANE_W-1:0] t;
      t = {x, x} << amt;
      return t[2*LANE_W-1:LANE_W];
   endfunction

   // Round key lane: master key lane tweaked by round index and lane index.
   function automatic lane_t rk_lane(input lane_t key_lane, input logic [7:0] r,
                                     input logic [7:0] i);
      return key_lane ^ {r, i};
   endfunction

endpackage

// File: rtl/warx_mix_layer.sv
// Combinational WARX lane-mixing layer: Y[i] = X[i] ^ X[i+2] ^ rotl16(X[i+5], ROT_MIX).
// Shared between the encryption and decryption round controllers.
module warx_mix_layer
   import warx_pkg::*;
#(
   parameter int unsigned ROT_MIX = 3
) (
   input  logic [127:0] mix_in,
   output logic [127:0] mix_out
);

   state_t x;
   state_t y;

   assign x = mix_in;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign y[g] = x[g] ^ x[(g + 2) % LANES] ^ rotl16(x[(g + 5) % LANES], 4'(ROT_MIX));
   end

   assign mix_out = y;

endmodule

// File: rtl/warx_round_ctrl.sv
// Iterative WARX round controller: loops the state through the external ARX layer,
// MIX and round-key addition. WARX_FINAL_MIX_EN keeps MIX in the final round.
module warx_round_ctrl
   import warx_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned ROT_MIX    = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] pt_i,
   input  logic [127:0] key_i,
   output logic [127:0] arx_state_o,
   input  logic [127:0] arx_state_i,
   input  logic         abort_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ct_o,
   output logic [7:0]   round_o,
   output logic         busy_o
);

   localparam logic [7:0] LastRound = 8'(NUM_ROUNDS - 1);

   fsm_e       fsm_q, fsm_d;
   state_t     state_q, state_d;
   state_t     key_q, key_d;
   logic [7:0] r_q, r_d;

   state_t     mixed;
   state_t     rk;
   state_t     round_val;
   logic       last_round;

   assign last_round = (r_q == LastRound);

   warx_mix_layer #(
      .ROT_MIX (ROT_MIX)
   ) u_mix (
      .mix_in  (arx_state_i),
      .mix_out (mixed)
   );

   for (genvar g = 0; g < LANES; g++) begin : g_rk
      assign rk[g] = rk_lane(key_q[g], r_q, 8'(g));
   end

`ifdef WARX_FINAL_MIX_EN
   assign round_val = mixed ^ rk;
`else
   // The last round stays linear-layer-free so decryption can start with an ARX inverse.
   assign round_val = last_round ? (arx_state_i ^ rk) : (mixed ^ rk);
`endif

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      r_d     = r_q;
      unique case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = pt_i ^ key_i;
               key_d   = key_i;
               r_d     = 8'd0;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_val;
            r_d     = r_q + 8'd1;
            if (last_round) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d = IDLE;
               r_d   = 8'd0;
            end
         end
         default: begin
            fsm_d = IDLE;
            r_d   = 8'd0;
         end
      endcase
      // Abort overrides everything; the state and key registers keep their contents.
      if (abort_i) begin
         fsm_d   = IDLE;
         r_d     = 8'd0;
         state_d = state_q;
         key_d   = key_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         key_q   <= '0;
         r_q     <= 8'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         r_q     <= r_d;
      end
   end

   assign in_ready    = (fsm_q == IDLE);
   assign busy_o      = (fsm_q == RUN);
   assign out_valid   = (fsm_q == DONE);
   assign ct_o        = state_q;
   assign arx_state_o = state_q;
   assign round_o     = r_q;

endmodule
